dotprod_vec_loader: RTL and testbench
=====================================

// Module: dotprod_vec_loader
// PURPOSE
//  Upstream feeder and sequencer for the dotprod kernel. Accepts a valid/ready stream of
//  (a,b) element pairs and buffers them in two local RAMs. It serves those RAMs on the
//  kernel's a_*/b_* read ports and drives the kernel's n input. It starts the kernel,
//  captures ap_return and presents the sum on a valid/ready result port.
// PARAMETERS
//  DATA_W  32  element and result width
//  DEPTH   16  max elements per vector (buffer depth)
//  ADDR_W  4   log2(DEPTH); buffer index width
// PORTS
//  ap_clk       in   1         clock
//  ap_rst_n     in   1         reset
//  s_valid      in   1         input pair valid
//  s_ready      out  1         input pair accepted when s_valid&s_ready
//  s_a          in   DATA_W    element of vector a
//  s_b          in   DATA_W    element of vector b
//  s_last       in   1         final pair of the vector
//  dp_rst_n     out  1         kernel reset: ap_rst_n AND local pulse
//  dp_start     out  1         kernel ap_start
//  dp_done      in   1         kernel ap_done (sticky until kernel reset)
//  dp_return    in   DATA_W    kernel ap_return
//  dp_n         out  32        element count; drives kernel n
//  a_address0   in   32        kernel read address, vector a
//  a_ce0        in   1         kernel read enable, vector a
//  a_q0         out  DATA_W    read data, vector a
//  b_address0   in   32        kernel read address, vector b
//  b_ce0        in   1         kernel read enable, vector b
//  b_q0         out  DATA_W    read data, vector b
//  r_valid      out  1         result valid
//  r_ready      in   1         result accepted when r_valid&r_ready
//  r_data       out  DATA_W    dot product, mod 2^DATA_W
//  r_len        out  ADDR_W+1  element count of this result
//  r_ovf        out  1         vector truncated at DEPTH, no s_last seen
// BEHAVIOUR
//  - Reset is ap_rst_n, asynchronous, active-low; clock is ap_clk.
//  - Reset values: s_ready=0, dp_start=0, local dp_rst_n pulse inactive, dp_n=0, a_q0=b_q0=0,
//    r_valid=0, r_data=0, r_len=0, r_ovf=0. RAM contents are not reset.
//  - FSM states: FILL -> KRST -> RUN -> RESULT -> FILL. The reset state is FILL.
//  - FILL: s_ready=1. Each handshake writes s_a/s_b at wr_ptr, then wr_ptr++.
//    Exit on an s_last beat or on the beat at wr_ptr==DEPTH-1.
//    On exit: dp_n = count; r_ovf=1 if the exit was on DEPTH without s_last.
//    A single s_last beat gives length 1. Zero-length vectors cannot occur.
//  - KRST: dp_rst_n=0 for exactly 1 cycle to clear the kernel's sticky ap_done, then RUN.
//  - RUN: dp_start=1 until dp_done is seen. dp_done is ignored on the first RUN cycle.
//    On dp_done=1: latch r_data<=dp_return and r_len<=dp_n, set dp_start=0, go to RESULT.
//  - RESULT: r_valid=1. r_data, r_len and r_ovf are stable until the r handshake.
//    After the handshake, next cycle: r_valid=0, r_ovf cleared, wr_ptr=0, back to FILL.
//  - s_ready=0 in every state except FILL; no input is accepted while the kernel runs.
//  - Read ports have 1-cycle latency: when ce0=1, q0 <= mem[address0[ADDR_W-1:0]] on the
//    next edge. q0 holds its value when ce0=0. Any address >= DEPTH returns 0.
//    The kernel samples q0 2 cycles after ce0, so this latency is safe.
//  - RAM writes happen only in FILL and reads only in RUN, so there is no port collision.
//  - Reset in any state: back to FILL and the kernel is held in reset. In-flight
//    result and partial vector are discarded.
// TESTING
//  - (1,5),(2,6),(3,7),(4,8) with s_last on beat 4 -> dp_n=4; r_data=70, r_len=4, r_ovf=0.
//  - Single pair (0x0000FFFF,0x00010001) with s_last -> r_data=0xFFFFFFFF, r_len=1.
//  - 16 beats of (1,1), no s_last -> s_ready=0 after beat 16; r_data=16, r_len=16, r_ovf=1.
//  - r_ready low 20 cycles -> outputs stable and s_ready=0. After accept, a packet of
//    (2,3) with s_last -> r_data=6; KRST pulse observed as dp_rst_n low for 1 cycle.
//  - ap_rst_n low mid-RUN -> dp_start=0, r_valid=0. s_ready=1 after release.
//    Next packet (3,3) -> r_data=9.
//  - Read ports: ce0=1 at addr 20 -> q0=0 next cycle; ce0=1 at addr 2 -> stored element.

Source files
------------

// File: rtl/dotprod_vec_loader.sv
// Input buffer and sequencer for the dotprod kernel: collects (a,b) pairs,
// serves them on the kernel read ports, runs the kernel and returns the sum.
module dotprod_vec_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    output logic              dp_rst_n,
    output logic              dp_start,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_return,
    output logic [31:0]       dp_n,
    input  logic [31:0]       a_address0,
    input  logic              a_ce0,
    output logic [DATA_W-1:0] a_q0,
    input  logic [31:0]       b_address0,
    input  logic              b_ce0,
    output logic [DATA_W-1:0] b_q0,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic [ADDR_W:0]   r_len,
    output logic              r_ovf
);

    typedef enum logic [1:0] {
        FILL,
        KRST,
        RUN,
        RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]       dp_n_q, dp_n_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [ADDR_W:0]   r_len_q, r_len_d;
    logic              r_ovf_q, r_ovf_d;
    logic              s_ready_q;
    logic              first_q;
    logic [DATA_W-1:0] a_q0_q, b_q0_q;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic              s_fire;
    logic              at_end;
    logic [ADDR_W:0]   count;
    logic              a_in_rng;
    logic              b_in_rng;

    assign s_fire   = s_valid & s_ready_q;
    assign at_end   = (wr_ptr_q == ADDR_W'(DEPTH - 1));
    assign count    = {1'b0, wr_ptr_q} + 1'b1;
    assign a_in_rng = (a_address0 < 32'(DEPTH));
    assign b_in_rng = (b_address0 < 32'(DEPTH));

    assign s_ready  = s_ready_q;
    assign dp_start = (state_q == RUN);
    assign dp_rst_n = ap_rst_n & (state_q != KRST);
    assign dp_n     = dp_n_q;
    assign a_q0     = a_q0_q;
    assign b_q0     = b_q0_q;
    assign r_valid  = (state_q == RESULT);
    assign r_data   = r_data_q;
    assign r_len    = r_len_q;
    assign r_ovf    = r_ovf_q;

    // Next-state logic: fill buffers, pulse kernel reset, run, hold result.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        dp_n_d   = dp_n_q;
        r_data_d = r_data_q;
        r_len_d  = r_len_q;
        r_ovf_d  = r_ovf_q;
        unique case (state_q)
            FILL: begin
                if (s_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_last || at_end) begin
                        state_d = KRST;
                        dp_n_d  = 32'(count);
                        r_ovf_d = at_end & ~s_last;
                    end
                end
            end
            KRST: begin
                state_d = RUN;
            end
            RUN: begin
                // A stale ap_done is not trusted on the first RUN cycle.
                if (dp_done && !first_q) begin
                    r_data_d = dp_return;
                    r_len_d  = dp_n_q[ADDR_W:0];
                    state_d  = RESULT;
                end
            end
            RESULT: begin
                if (r_ready) begin
                    state_d  = FILL;
                    r_ovf_d  = 1'b0;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= FILL;
            wr_ptr_q  <= '0;
            dp_n_q    <= '0;
            r_data_q  <= '0;
            r_len_q   <= '0;
            r_ovf_q   <= 1'b0;
            s_ready_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            dp_n_q    <= dp_n_d;
            r_data_q  <= r_data_d;
            r_len_q   <= r_len_d;
            r_ovf_q   <= r_ovf_d;
            s_ready_q <= (state_d == FILL);
            first_q   <= (state_q == KRST);
        end
    end

    // Buffer writes on each accepted input pair.
    always_ff @(posedge ap_clk) begin
        if (s_fire) begin
            mem_a[wr_ptr_q] <= s_a;
            mem_b[wr_ptr_q] <= s_b;
        end
    end

    // Vector a read port: one-cycle latency, zero outside the buffer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q0_q <= '0;
        end else if (a_ce0) begin
            a_q0_q <= a_in_rng ? mem_a[a_address0[ADDR_W-1:0]] : '0;
        end
    end

    // Vector b read port: one-cycle latency, zero outside the buffer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            b_q0_q <= '0;
        end else if (b_ce0) begin
            b_q0_q <= b_in_rng ? mem_b[b_address0[ADDR_W-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_dotprod_vec_loader.sv
// Directed bench for dotprod_vec_loader with a behavioural dotprod kernel
// that reads the buffers through the a/b ports.
module tb_dotprod_vec_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_a = '0;
    logic [DATA_W-1:0] s_b = '0;
    logic              s_last = 1'b0;
    logic              dp_rst_n;
    logic              dp_start;
    logic              dp_done;
    logic [DATA_W-1:0] dp_return;
    logic [31:0]       dp_n;
    logic [31:0]       a_address0;
    logic              a_ce0;
    logic [DATA_W-1:0] a_q0;
    logic [31:0]       b_address0;
    logic              b_ce0;
    logic [DATA_W-1:0] b_q0;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W:0]   r_len;
    logic              r_ovf;

    logic              man = 1'b0;
    logic              man_ce = 1'b0;
    logic [31:0]       man_addr = '0;

    logic              k_busy;
    logic              k_pend;
    logic              k_done;
    logic [31:0]       k_idx;
    logic [DATA_W-1:0] k_acc;
    logic [DATA_W-1:0] k_ret;
    logic              k_ce;

    int n_pass = 0;
    int n_total = 0;
    int krst;

    always #5 ap_clk = ~ap_clk;

    dotprod_vec_loader #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_last    (s_last),
        .dp_rst_n  (dp_rst_n),
        .dp_start  (dp_start),
        .dp_done   (dp_done),
        .dp_return (dp_return),
        .dp_n      (dp_n),
        .a_address0(a_address0),
        .a_ce0     (a_ce0),
        .a_q0      (a_q0),
        .b_address0(b_address0),
        .b_ce0     (b_ce0),
        .b_q0      (b_q0),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_len     (r_len),
        .r_ovf     (r_ovf)
    );

    assign k_ce       = k_busy && (k_idx < dp_n);
    assign a_address0 = man ? man_addr : k_idx;
    assign b_address0 = man ? man_addr : k_idx;
    assign a_ce0      = man ? man_ce : k_ce;
    assign b_ce0      = man ? man_ce : k_ce;
    assign dp_done    = k_done;
    assign dp_return  = k_ret;

    // Kernel model: reads n elements, accumulates one cycle after each read.
    always_ff @(posedge ap_clk or negedge dp_rst_n) begin
        if (!dp_rst_n) begin
            k_busy <= 1'b0;
            k_pend <= 1'b0;
            k_done <= 1'b0;
            k_idx  <= '0;
            k_acc  <= '0;
            k_ret  <= '0;
        end else begin
            k_pend <= k_ce;
            if (k_pend) k_acc <= k_acc + a_q0 * b_q0;
            if (!k_busy && !k_done && dp_start) begin
                k_busy <= 1'b1;
                k_idx  <= '0;
                k_acc  <= '0;
            end else if (k_busy) begin
                if (k_idx < dp_n) begin
                    k_idx <= k_idx + 1;
                end else if (!k_pend) begin
                    k_busy <= 1'b0;
                    k_done <= 1'b1;
                    k_ret  <= k_acc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic last);
        int n;
        n = 0;
        s_a = a;
        s_b = b;
        s_last = last;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("s_ready_wait", 64'(s_ready), 1);
        @(negedge ap_clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_result(output int lo);
        int n;
        n = 0;
        lo = 0;
        while (!r_valid && n < 300) begin
            if (!dp_rst_n) lo++;
            @(negedge ap_clk);
            n++;
        end
        chk("result_wait", 64'(r_valid), 1);
    endtask

    task automatic accept();
        r_ready = 1'b1;
        @(negedge ap_clk);
        r_ready = 1'b0;
        chk("acc_r_valid", 64'(r_valid), 0);
        chk("acc_r_ovf", 64'(r_ovf), 0);
        chk("acc_s_ready", 64'(s_ready), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge ap_clk);
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_dp_start", 64'(dp_start), 0);
        chk("rst_dp_rst_n", 64'(dp_rst_n), 0);
        chk("rst_dp_n", 64'(dp_n), 0);
        chk("rst_a_q0", 64'(a_q0), 0);
        chk("rst_b_q0", 64'(b_q0), 0);
        chk("rst_r_valid", 64'(r_valid), 0);
        chk("rst_r_data", 64'(r_data), 0);
        chk("rst_r_len", 64'(r_len), 0);
        chk("rst_r_ovf", 64'(r_ovf), 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rel_s_ready", 64'(s_ready), 1);

        send(1, 5, 1'b0);
        send(2, 6, 1'b0);
        send(3, 7, 1'b0);
        send(4, 8, 1'b1);
        chk("t1_dp_n", 64'(dp_n), 4);
        chk("t1_s_ready", 64'(s_ready), 0);
        wait_result(krst);
        chk("t1_r_data", 64'(r_data), 70);
        chk("t1_r_len", 64'(r_len), 4);
        chk("t1_r_ovf", 64'(r_ovf), 0);
        accept();

        man = 1'b1;
        man_ce = 1'b1;
        man_addr = 20;
        @(negedge ap_clk);
        chk("rd_a_addr20", 64'(a_q0), 0);
        chk("rd_b_addr20", 64'(b_q0), 0);
        man_addr = 2;
        @(negedge ap_clk);
        chk("rd_a_addr2", 64'(a_q0), 3);
        chk("rd_b_addr2", 64'(b_q0), 7);
        man_ce = 1'b0;
        man_addr = 1;
        @(negedge ap_clk);
        chk("rd_a_hold", 64'(a_q0), 3);
        chk("rd_b_hold", 64'(b_q0), 7);
        man = 1'b0;

        send(32'h0000FFFF, 32'h00010001, 1'b1);
        wait_result(krst);
        chk("t2_r_data", 64'(r_data), 64'hFFFF_FFFF);
        chk("t2_r_len", 64'(r_len), 1);
        chk("t2_r_ovf", 64'(r_ovf), 0);
        accept();

        for (int i = 0; i < 16; i++) send(1, 1, 1'b0);
        chk("t3_s_ready", 64'(s_ready), 0);
        chk("t3_dp_n", 64'(dp_n), 16);
        wait_result(krst);
        chk("t3_r_data", 64'(r_data), 16);
        chk("t3_r_len", 64'(r_len), 16);
        chk("t3_r_ovf", 64'(r_ovf), 1);

        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            chk("t4_stall", {r_valid, s_ready, r_ovf, r_len, r_data},
                {1'b1, 1'b0, 1'b1, 5'd16, 32'd16});
        end
        accept();
        send(2, 3, 1'b1);
        wait_result(krst);
        chk("t4_krst_cycles", 64'(krst), 1);
        chk("t4_r_data", 64'(r_data), 6);
        chk("t4_r_len", 64'(r_len), 1);
        accept();

        for (int i = 0; i < 4; i++) send(1, 1, i == 3);
        n = 0;
        while (!dp_start && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("t5_dp_start", 64'(dp_start), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("t5_rst_dp_start", 64'(dp_start), 0);
        chk("t5_rst_r_valid", 64'(r_valid), 0);
        chk("t5_rst_dp_rst_n", 64'(dp_rst_n), 0);
        chk("t5_rst_s_ready", 64'(s_ready), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("t5_rel_s_ready", 64'(s_ready), 1);
        chk("t5_rel_r_valid", 64'(r_valid), 0);
        send(3, 3, 1'b1);
        wait_result(krst);
        chk("t5_r_data", 64'(r_data), 9);
        chk("t5_r_len", 64'(r_len), 1);
        chk("t5_r_ovf", 64'(r_ovf), 0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
